// File: rtl/bomb_game_ctrl.sv
// bomb_game_ctrl
// Game sequencer for the bomb-defusal timer datapath.
// It arms and clears the countdown timer and latches the time mode.
// It collects keypad digits and compares each complete 4-digit entry
// against CODE; every wrong entry counts as a strike.
// It freezes the timer on a win. The final outcome comes from the
// timer's bomb flag or from reaching the strike limit.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   start     debounced start/restart button; acted on at its rising edge
//   mode_sel  requested time mode, latched into timeMod while idle
//   key_valid one-cycle strobe qualifying key_digit
//   key_digit BCD digit from the keypad
//   bomb      timer expiry level
//   defused   freeze request to the timer (high = timer does not count)
//   timeMod   latched time mode sent to the timer
//   tmr_clr   one-cycle clear pulse to the timer (first ARMED cycle)
//   state     00 IDLE, 01 ARMED, 10 DEFUSED, 11 EXPLODED
//   strikes   wrong-entry count, saturating at MAX_STRIKES
//   digit_cnt digits held in the current entry (0..3)
//   win       high while DEFUSED
//   explode   high while EXPLODED
module bomb_game_ctrl #(
  parameter logic [15:0] CODE        = 16'h1234,
  parameter int          MAX_STRIKES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode_sel,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       bomb,
  output logic       defused,
  output logic       timeMod,
  output logic       tmr_clr,
  output logic [1:0] state,
  output logic [1:0] strikes,
  output logic [2:0] digit_cnt,
  output logic       win,
  output logic       explode
);

  localparam logic [1:0] S_IDLE     = 2'b00;
  localparam logic [1:0] S_ARMED    = 2'b01;
  localparam logic [1:0] S_DEFUSED  = 2'b10;
  localparam logic [1:0] S_EXPLODED = 2'b11;

  localparam logic [1:0] STRIKE_LIMIT = 2'(MAX_STRIKES);

  logic        start_q;
  logic [15:0] entry_buf;

  logic        start_rise;
  logic        key_ok;
  logic        entry_full;
  logic        code_match;
  logic [15:0] shifted;
  logic [1:0]  strikes_inc;

  logic [1:0]  state_n;
  logic [1:0]  strikes_n;
  logic [2:0]  cnt_n;
  logic [15:0] buf_n;
  logic        clr_n;

  assign start_rise = start & ~start_q;
  assign key_ok     = key_valid & (key_digit <= 4'd9);
  assign shifted    = {entry_buf[11:0], key_digit};
  // The 4th digit is compared as it shifts in, so the verdict lands on
  // the same edge that samples the strobe.
  assign entry_full = key_ok & (digit_cnt == 3'd3);
  assign code_match = (shifted == CODE);
  // Saturating increment; the limit check normally prevents overflow,
  // but this keeps the counter safe even if MAX_STRIKES is misconfigured.
  assign strikes_inc = (strikes == STRIKE_LIMIT) ? strikes : strikes + 2'd1;

  always_comb begin
    state_n   = state;
    strikes_n = strikes;
    cnt_n     = digit_cnt;
    buf_n     = entry_buf;
    clr_n     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_rise) begin
          state_n   = S_ARMED;
          clr_n     = 1'b1;
          strikes_n = 2'd0;
          cnt_n     = 3'd0;
          buf_n     = 16'h0000;
        end
      end
      S_ARMED: begin
        // Expiry beats a simultaneous keystroke; the key is dropped.
        if (bomb) begin
          state_n = S_EXPLODED;
        end else if (key_ok) begin
          if (entry_full) begin
            cnt_n = 3'd0;
            buf_n = 16'h0000;
            if (code_match) begin
              state_n = S_DEFUSED;
            end else begin
              strikes_n = strikes_inc;
              if (strikes_inc == STRIKE_LIMIT) begin
                state_n = S_EXPLODED;
              end
            end
          end else begin
            buf_n = shifted;
            cnt_n = digit_cnt + 3'd1;
          end
        end
      end
      S_DEFUSED, S_EXPLODED: begin
        if (start_rise) begin
          state_n   = S_IDLE;
          strikes_n = 2'd0;
          cnt_n     = 3'd0;
          buf_n     = 16'h0000;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Status outputs are decoded from the next state so that they change
  // on the same edge as state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      strikes   <= 2'd0;
      digit_cnt <= 3'd0;
      entry_buf <= 16'h0000;
      start_q   <= 1'b0;
      tmr_clr   <= 1'b0;
      timeMod   <= 1'b0;
      defused   <= 1'b1;
      win       <= 1'b0;
      explode   <= 1'b0;
    end else begin
      state     <= state_n;
      strikes   <= strikes_n;
      digit_cnt <= cnt_n;
      entry_buf <= buf_n;
      start_q   <= start;
      tmr_clr   <= clr_n;
      if (state == S_IDLE) begin
        timeMod <= mode_sel;
      end
      defused   <= (state_n != S_ARMED);
      win       <= (state_n == S_DEFUSED);
      explode   <= (state_n == S_EXPLODED);
    end
  end

endmodule
